// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with a registered output stage.
// Optional ARB_LOCK_EN adds req0_lock/req1_lock to hold a grant past HOLD_MAX.
module mux_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic [1:0]        grant
);

  localparam int CW = $clog2(HOLD_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic [CW-1:0]       r_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;

  logic   w_slot_free;
  logic   w_acc0;
  logic   w_acc1;
  logic   w_acc;
  logic   w_cur_valid;
  logic   w_oth_valid;
  logic   w_oth_side;
  logic   w_cur_lock;
  logic   w_at_max;
  state_t w_oth_state;

  assign w_slot_free = ~r_out_valid | out_ready;

  assign req0_ready = (r_state == GNT0) & w_slot_free;
  assign req1_ready = (r_state == GNT1) & w_slot_free;

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;
  assign w_acc  = w_acc0 | w_acc1;

  assign w_cur_valid = (r_state == GNT1) ? req1_valid : req0_valid;
  assign w_oth_valid = (r_state == GNT1) ? req0_valid : req1_valid;
  assign w_oth_side  = (r_state == GNT0);
  assign w_oth_state = (r_state == GNT0) ? GNT1 : GNT0;
  assign w_at_max    = (r_cnt == CW'(HOLD_MAX - 1));

`ifdef ARB_LOCK_EN
  assign w_cur_lock = (r_state == GNT0) ? req0_lock :
                      (r_state == GNT1) ? req1_lock : 1'b0;
`else
  assign w_cur_lock = 1'b0;
`endif

  assign sel       = (r_state == GNT1);
  assign grant     = {r_state == GNT1, r_state == GNT0};
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Grant FSM: round-robin pick from IDLE, rotate after HOLD_MAX beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0_valid & req1_valid) begin
            r_state <= r_last ? GNT0 : GNT1;
            r_last  <= ~r_last;
            r_cnt   <= '0;
          end else if (req0_valid) begin
            r_state <= GNT0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
          end else if (req1_valid) begin
            r_state <= GNT1;
            r_last  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GNT0, GNT1: begin
          if (!w_cur_valid) begin
            r_cnt <= '0;
            if (w_oth_valid) begin
              r_state <= w_oth_state;
              r_last  <= w_oth_side;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_acc) begin
            if (w_at_max & w_cur_lock) begin
              r_cnt <= r_cnt;
            end else if (w_at_max) begin
              r_cnt <= '0;
              if (w_oth_valid) begin
                r_state <= w_oth_state;
                r_last  <= w_oth_side;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: load accepted beat, drain when consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (1'b1)
        w_acc0: begin
          r_out_valid <= 1'b1;
          r_out_data  <= req0_data;
        end
        w_acc1: begin
          r_out_valid <= 1'b1;
          r_out_data  <= req1_data;
        end
        default: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic
// checked against a beat-level round-robin model.
module tb_mux_rr_arbiter;

  localparam int DW = 8;
  localparam int HM = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0;
  logic          v1 = 1'b0;
  logic          ordy = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
`ifdef ARB_LOCK_EN
  logic          l0 = 1'b0;
  logic          l1 = 1'b0;
`endif
  logic          r0, r1, ov, sel;
  logic [DW-1:0] od;
  logic [1:0]    gr;

  int total = 0;
  int bad   = 0;

  int            m_side  = -1;
  int            m_last  = 1;
  int            m_beats = 0;
  bit            m_ov    = 1'b0;
  logic [DW-1:0] m_od    = '0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(v0),
    .req0_data(d0),
    .req0_ready(r0),
    .req1_valid(v1),
    .req1_data(d1),
    .req1_ready(r1),
`ifdef ARB_LOCK_EN
    .req0_lock(l0),
    .req1_lock(l1),
`endif
    .out_valid(ov),
    .out_data(od),
    .out_ready(ordy),
    .sel(sel),
    .grant(gr)
  );

  task automatic model_reset();
    m_side  = -1;
    m_last  = 1;
    m_beats = 0;
    m_ov    = 1'b0;
    m_od    = '0;
  endtask

  // Advance the model by one beat-slot from current inputs, then clock.
  task automatic tick();
    bit [1:0]      v;
    bit            lk;
    bit            acc;
    int            n;
    int            m;
    int            nxt;
    logic [DW-1:0] dsel;
    v    = {v1, v0};
    lk   = 1'b0;
`ifdef ARB_LOCK_EN
    if (m_side == 0) lk = l0;
    else if (m_side == 1) lk = l1;
`endif
    dsel = (m_side == 1) ? d1 : d0;
    acc  = 1'b0;
    if (m_side >= 0) acc = v[m_side] && (!m_ov || ordy);
    if (acc) begin
      m_ov = 1'b1;
      m_od = dsel;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    nxt = m_side;
    if (m_side < 0) begin
      if (v0 && v1) nxt = 1 - m_last;
      else if (v0) nxt = 0;
      else if (v1) nxt = 1;
    end else begin
      n = m_side;
      m = 1 - n;
      if (!v[n]) begin
        nxt = v[m] ? m : -1;
      end else if (acc) begin
        m_beats++;
        if (m_beats >= HM) begin
          if (lk) m_beats = HM;
          else begin
            m_beats = 0;
            if (v[m]) nxt = m;
          end
        end
      end
    end
    if (nxt != m_side) begin
      m_beats = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_side = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_ov got=%b exp=0", ov); end
    total++; if (od !== 8'h00) begin bad++; $display("FAIL rst_od got=%h exp=00", od); end
    total++; if (gr !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", gr); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel got=%b exp=0", sel); end
    total++; if ({r1, r0} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {r1, r0}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_source();
    logic [DW-1:0] seq [3];
    seq[0] = 8'h11;
    seq[1] = 8'h22;
    seq[2] = 8'h33;
    v0 = 1'b1; v1 = 1'b0; d0 = seq[0]; ordy = 1'b1;
    #1;
    total++; if (gr !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", gr); end
    tick();
    total++; if (gr !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", gr); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL single_ov0 got=%b exp=0", ov); end
    for (int k = 0; k < 3; k++) begin
      d0 = seq[k];
      tick();
      total++; if (ov !== 1'b1) begin bad++; $display("FAIL single_ov k=%0d got=%b exp=1", k, ov); end
      total++; if (od !== seq[k]) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, od, seq[k]); end
      total++; if (sel !== 1'b0) begin bad++; $display("FAIL single_sel k=%0d got=%b exp=0", k, sel); end
    end
    v0 = 1'b0;
    tick();
    total++; if (gr !== 2'b00) begin bad++; $display("FAIL single_end_grant got=%b exp=00", gr); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL single_end_ov got=%b exp=0", ov); end
  endtask

  task automatic test_reset_midflight();
    v0 = 1'b1; d0 = 8'h5A; ordy = 1'b0;
    tick();
    tick();
    total++; if (od !== 8'h5A) begin bad++; $display("FAIL mid_pre_od got=%h exp=5a", od); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL mid_ov got=%b exp=0", ov); end
    total++; if (od !== 8'h00) begin bad++; $display("FAIL mid_od got=%h exp=00", od); end
    total++; if (gr !== 2'b00) begin bad++; $display("FAIL mid_grant got=%b exp=00", gr); end
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL mid_sel got=%b exp=0", sel); end
    total++; if ({r1, r0} !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b exp=00", {r1, r0}); end
    v0 = 1'b0;
    rst_n = 1'b1;
    tick();
    total++; if (gr !== 2'b00) begin bad++; $display("FAIL mid_after_grant got=%b exp=00", gr); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL mid_after_ov got=%b exp=0", ov); end
  endtask

  task automatic test_hold_rotation();
    int            exp_side;
    logic [DW-1:0] exp_d;
    v0 = 1'b1; v1 = 1'b1; ordy = 1'b1;
    tick();
    for (int b = 0; b < 24; b++) begin
      exp_side = (b / HM) % 2;
      total++;
      if (gr !== (exp_side == 1 ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rot_grant b=%0d got=%b exp_side=%0d", b, gr, exp_side);
      end
      total++;
      if (sel !== exp_side[0]) begin
        bad++; $display("FAIL rot_sel b=%0d got=%b exp=%0d", b, sel, exp_side);
      end
      d0 = 8'(b);
      d1 = 8'(b) | 8'h80;
      exp_d = (exp_side == 1) ? d1 : d0;
      tick();
      total++;
      if (ov !== 1'b1 || od !== exp_d) begin
        bad++; $display("FAIL rot_data b=%0d got=%b/%h exp=1/%h", b, ov, od, exp_d);
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    v0 = 1'b1; v1 = 1'b0; d0 = 8'hA5; ordy = 1'b1;
    tick();
    tick();
    total++; if (od !== 8'hA5) begin bad++; $display("FAIL bp_load got=%h exp=a5", od); end
    ordy = 1'b0; d0 = 8'hB6;
    #1;
    total++; if ({r1, r0} !== 2'b00) begin bad++; $display("FAIL bp_ready got=%b exp=00", {r1, r0}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (ov !== 1'b1 || od !== 8'hA5) begin
        bad++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/a5", k, ov, od);
      end
      total++;
      if ({r1, r0} !== 2'b00 || gr !== 2'b01) begin
        bad++; $display("FAIL bp_stall k=%0d ready=%b grant=%b exp=00/01", k, {r1, r0}, gr);
      end
    end
    ordy = 1'b1;
    #1;
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got=%b exp=1", r0); end
    tick();
    total++; if (od !== 8'hB6) begin bad++; $display("FAIL bp_resume got=%h exp=b6", od); end
    v1 = 1'b1; d0 = 8'hC7;
    tick();
    total++; if (gr !== 2'b01 || od !== 8'hC7) begin bad++; $display("FAIL bp_cnt3 got=%b/%h exp=01/c7", gr, od); end
    d0 = 8'hD8;
    tick();
    total++; if (gr !== 2'b10 || od !== 8'hD8) begin bad++; $display("FAIL bp_cnt4 got=%b/%h exp=10/d8", gr, od); end
    v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_drop_valid();
    v0 = 1'b1; v1 = 1'b0; ordy = 1'b1;
    tick();
    total++; if (gr !== 2'b01) begin bad++; $display("FAIL drop_start got=%b exp=01", gr); end
    v1 = 1'b1;
    tick();
    tick();
    v0 = 1'b0;
    tick();
    total++; if (gr !== 2'b10 || sel !== 1'b1) begin bad++; $display("FAIL drop_switch got=%b/%b exp=10/1", gr, sel); end
    v0 = 1'b1;
    for (int k = 0; k < HM - 1; k++) begin
      tick();
      total++; if (gr !== 2'b10) begin bad++; $display("FAIL drop_cnt k=%0d got=%b exp=10", k, gr); end
    end
    tick();
    total++; if (gr !== 2'b01) begin bad++; $display("FAIL drop_rotate got=%b exp=01", gr); end
    v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    v0 = 1'b1; v1 = 1'b0; l0 = 1'b1; ordy = 1'b1;
    tick();
    v1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (gr !== 2'b01) begin bad++; $display("FAIL lock_hold k=%0d got=%b exp=01", k, gr); end
    end
    l0 = 1'b0;
    tick();
    total++; if (gr !== 2'b10) begin bad++; $display("FAIL lock_release got=%b exp=10", gr); end
    v0 = 1'b0; v1 = 1'b0;
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0] exp_gr;
    logic       exp_r0;
    logic       exp_r1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) v0 = ~v0;
      if ($urandom_range(0, 3) == 0) v1 = ~v1;
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) l0 = ~l0;
      if ($urandom_range(0, 15) == 0) l1 = ~l1;
`endif
      #1;
      exp_gr = (m_side == 0) ? 2'b01 : (m_side == 1) ? 2'b10 : 2'b00;
      exp_r0 = (m_side == 0) && (!m_ov || ordy);
      exp_r1 = (m_side == 1) && (!m_ov || ordy);
      total++;
      if (gr !== exp_gr || sel !== exp_gr[1]) begin
        bad++; $display("FAIL rnd_grant i=%0d got=%b/%b exp=%b", i, gr, sel, exp_gr);
      end
      total++;
      if (r0 !== exp_r0 || r1 !== exp_r1) begin
        bad++; $display("FAIL rnd_ready i=%0d got=%b%b exp=%b%b", i, r1, r0, exp_r1, exp_r0);
      end
      total++;
      if (ov !== m_ov || od !== m_od) begin
        bad++; $display("FAIL rnd_out i=%0d got=%b/%h exp=%b/%h", i, ov, od, m_ov, m_od);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_reset_midflight();
    test_hold_rotation();
    test_backpressure();
    test_drop_valid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
